des_keysched: RTL and testbench

- Iterative DES key-schedule generator sitting directly upstream of the pipelined `des` core.
- Captures a 64-bit key on `keyin` and produces the 16 round subkeys (48 bits each) over 16 clock cycles, one per cycle.
- Presents all 16 subkeys on a flat bus, ordered for encryption or decryption per `f`.
- Raises `keyready` when the whole set is valid, so the core can accept `datin` traffic.

---
 rtl/des_keysched.sv | 141 ++++++++++++++
 tb/tb_des_keysched.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/des_keysched.sv
// ============================================================================
// Module  : des_keysched
// Brief   : Iterative DES key schedule, one 48-bit round subkey per clock,
//           presented on a flat 16-slot bus in encrypt or decrypt order.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module des_keysched (
  input  logic         ck,
  input  logic         rst_n,
  input  logic         keyin,
  input  logic [63:0]  k,
  input  logic         f,
  output logic         keyready,
  output logic         busy,
  output logic [767:0] sk
);

  // Tables hold DES bit numbers (1 = MSB), first entry in the top field
  localparam logic [335:0] c_pc1 = {
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,
    6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18, 6'd10, 6'd2,
    6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,
    6'd60, 6'd52, 6'd44, 6'd36, 6'd63, 6'd55, 6'd47, 6'd39,
    6'd31, 6'd23, 6'd15, 6'd7,  6'd62, 6'd54, 6'd46, 6'd38,
    6'd30, 6'd22, 6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37,
    6'd29, 6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
  };
  localparam logic [287:0] c_pc2 = {
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
    6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
    6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
    6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
    6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };
  // Rounds 1, 2, 9 and 16 rotate by one; all others by two
  localparam logic [15:0] c_one_shift = 16'h8103;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] o;
    logic [5:0]  idx;
    o = '0;
    for (int m = 0; m < 56; m++) begin
      // 6-bit negate gives 64 - n, the vector position of DES bit n
      idx  = -c_pc1[m*6 +: 6];
      o[m] = key[idx];
    end
    return o;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] o;
    logic [5:0]  idx;
    o = '0;
    for (int m = 0; m < 48; m++) begin
      idx  = 6'd56 - c_pc2[m*6 +: 6];
      o[m] = cd[idx];
    end
    return o;
  endfunction

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_gen;
  logic [27:0]    r_c;
  logic [27:0]    r_d;
  logic [3:0]     r_cnt;
  logic           r_f;
  logic [767:0]   r_sk;
  logic [27:0]    w_c_rot;
  logic [27:0]    w_d_rot;
  logic [47:0]    w_subkey;
  logic [3:0]     w_slot;
  logic [55:0]    w_pc1;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gen       = 1'b0;
    case (r_state)
      GEN: begin
        w_gen = 1'b1;
        if (r_cnt == 4'd15) w_state_nxt = DONE;
      end
      IDLE, DONE: ;
      default: w_state_nxt = IDLE;
    endcase
    if (keyin) begin
      w_state_nxt = GEN;
      w_gen       = 1'b0;
    end
  end

  assign w_c_rot  = c_one_shift[r_cnt] ? {r_c[26:0], r_c[27]} : {r_c[25:0], r_c[27:26]};
  assign w_d_rot  = c_one_shift[r_cnt] ? {r_d[26:0], r_d[27]} : {r_d[25:0], r_d[27:26]};
  assign w_subkey = pc2({w_c_rot, w_d_rot});
  assign w_slot   = r_f ? r_cnt : 4'd15 - r_cnt;
  assign w_pc1    = pc1(k);

  // C and D come back to their PC-1 values after the full 28-position rotation
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_c   <= '0;
      r_d   <= '0;
      r_cnt <= '0;
      r_f   <= 1'b0;
      r_sk  <= '0;
    end else if (keyin) begin
      r_c   <= w_pc1[55:28];
      r_d   <= w_pc1[27:0];
      r_f   <= f;
      r_cnt <= '0;
    end else if (w_gen) begin
      r_c   <= w_c_rot;
      r_d   <= w_d_rot;
      r_cnt <= r_cnt + 4'd1;
      for (int i = 0; i < 16; i++) begin
        if (w_slot == i[3:0]) r_sk[i*48 +: 48] <= w_subkey;
      end
    end
  end

  assign keyready = (r_state == DONE);
  assign busy     = (r_state == GEN);
  assign sk       = r_sk;

endmodule

`default_nettype wire

// File: tb/tb_des_keysched.sv
// ============================================================================
// Module  : tb_des_keysched
// Brief   : Self-checking bench for des_keysched: known-answer table, random
//           keys against a table-driven schedule model, corner sequences.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_des_keysched;

  logic         ck;
  logic         rst_n;
  logic         keyin;
  logic [63:0]  k;
  logic         f;
  logic         keyready;
  logic         busy;
  logic [767:0] sk;

  des_keysched dut (
    .ck       (ck),
    .rst_n    (rst_n),
    .keyin    (keyin),
    .k        (k),
    .f        (f),
    .keyready (keyready),
    .busy     (busy),
    .sk       (sk)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  int n_cmp = 0;
  int n_err = 0;

  int pc1_t[56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                    63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int pc2_t[48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int shift_t[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  // Reference schedule built bit by bit from DES bit numbers (bit n weighs 2^(64-n))
  function automatic logic [767:0] ref_sched(input logic [63:0] key, input logic fenc);
    logic [27:0]  c, d;
    logic [55:0]  cd;
    logic [47:0]  sub;
    logic [767:0] o;
    int           slot;
    c = '0; d = '0; o = '0;
    for (int j = 0; j < 28; j++) begin
      c = {c[26:0], |(key & (64'd1 << (64 - pc1_t[j])))};
      d = {d[26:0], |(key & (64'd1 << (64 - pc1_t[28 + j])))};
    end
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < shift_t[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd  = {c, d};
      sub = '0;
      for (int j = 0; j < 48; j++) sub = {sub[46:0], |(cd & (56'd1 << (56 - pc2_t[j])))};
      slot = fenc ? r : 15 - r;
      o = o | ({720'd0, sub} << (48 * slot));
    end
    return o;
  endfunction

  // Stand-in keyed Feistel network consuming sk in pipeline-round order
  function automatic logic [31:0] fmix(input logic [31:0] r, input logic [47:0] kk);
    logic [47:0] t;
    t = {r, r[31:16]} ^ kk;
    return t[47:16] ^ (t[31:0] * 32'h9E3779B1) ^ {t[15:0], t[47:32]};
  endfunction

  function automatic logic [63:0] feistel(input logic [63:0] blk, input logic [767:0] sks);
    logic [31:0] l, r, nr;
    logic [47:0] kk;
    l = blk[63:32];
    r = blk[31:0];
    for (int i = 0; i < 16; i++) begin
      kk = 48'(sks >> (48 * i));
      nr = l ^ fmix(r, kk);
      l  = r;
      r  = nr;
    end
    return {r, l};
  endfunction

  task automatic chk(input string nm, input logic [767:0] act, input logic [767:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic load(input logic [63:0] key, input logic fv);
    keyin = 1'b1;
    k     = key;
    f     = fv;
    tick();
    keyin = 1'b0;
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    while (keyready !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  typedef struct {
    logic [63:0] key;
    logic        fv;
    int          slot;
    logic [47:0] exp;
  } vec_t;

  localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
  localparam logic [63:0] K1P = 64'h133457799BBCDFF0;
  localparam logic [63:0] K2  = 64'hDAB783857DCED3C8;

  vec_t         vecs[8];
  int           lat;
  logic [767:0] saved, sk_e, sk_d;
  logic [63:0]  rk, pt[3], ct[3];
  logic         rf;

  initial begin
    vecs[0] = '{K1,  1'b1, 0,  48'h1B02EFFC7072};
    vecs[1] = '{K1,  1'b1, 1,  48'h79AED9DBC9E5};
    vecs[2] = '{K1,  1'b1, 15, 48'hCB3D8B0E17F5};
    vecs[3] = '{K1,  1'b0, 0,  48'hCB3D8B0E17F5};
    vecs[4] = '{K1,  1'b0, 14, 48'h79AED9DBC9E5};
    vecs[5] = '{K1,  1'b0, 15, 48'h1B02EFFC7072};
    vecs[6] = '{K1P, 1'b1, 0,  48'h1B02EFFC7072};
    vecs[7] = '{K1P, 1'b1, 15, 48'hCB3D8B0E17F5};

    rst_n = 1'b0; keyin = 1'b0; k = '0; f = 1'b0;
    repeat (2) tick();
    chk("reset_keyready", {767'd0, keyready}, 768'd0);
    chk("reset_busy", {767'd0, busy}, 768'd0);
    chk("reset_sk", sk, 768'd0);
    rst_n = 1'b1;
    tick();

    // Known-answer table
    foreach (vecs[i]) begin
      load(vecs[i].key, vecs[i].fv);
      wait_ready(lat);
      chk($sformatf("kat_lat_%0d", i), 768'(lat), 768'd16);
      chk($sformatf("kat_slot_%0d", i), 768'(48'(sk >> (48 * vecs[i].slot))), 768'(vecs[i].exp));
    end

    // Busy during generation, exact latency, then DONE holds
    load(K1, 1'b1);
    repeat (8) tick();
    chk("busy_mid_gen", {767'd0, busy}, 768'd1);
    chk("ready_mid_gen", {767'd0, keyready}, 768'd0);
    repeat (7) tick();
    chk("ready_after_e15", {767'd0, keyready}, 768'd0);
    tick();
    chk("ready_after_e16", {767'd0, keyready}, 768'd1);
    chk("busy_after_e16", {767'd0, busy}, 768'd0);
    saved = sk;
    chk("enc_full_k1", sk, ref_sched(K1, 1'b1));
    repeat (5) tick();
    chk("done_hold_sk", sk, saved);
    chk("done_hold_ready", {767'd0, keyready}, 768'd1);

    // Parity bit and post-capture changes on k/f are ignored
    load(K1P, 1'b1);
    k = K2;
    f = 1'b0;
    wait_ready(lat);
    chk("parity_sampling_sk", sk, saved);

    // Restart at E5 with a second key
    load(K1, 1'b1);
    repeat (4) tick();
    load(K2, 1'b0);
    wait_ready(lat);
    chk("restart_lat", 768'(lat), 768'd16);
    chk("restart_sk", sk, ref_sched(K2, 1'b0));

    // keyin held three edges: generation uses the last key
    keyin = 1'b1; k = K2; f = 1'b1; tick();
    k = K1P; f = 1'b0; tick();
    k = K1; f = 1'b1; tick();
    keyin = 1'b0;
    wait_ready(lat);
    chk("hold_lat", 768'(lat), 768'd16);
    chk("hold_sk", sk, ref_sched(K1, 1'b1));

    // Random keys against the reference model
    for (int i = 0; i < 10; i++) begin
      rk = {$urandom, $urandom};
      rf = 1'($urandom_range(0, 1));
      load(rk, rf);
      wait_ready(lat);
      chk($sformatf("rand_lat_%0d", i), 768'(lat), 768'd16);
      chk($sformatf("rand_sk_%0d", i), sk, ref_sched(rk, rf));
    end

    // Encrypt then decrypt three blocks through a keyed Feistel network
    rk = {$urandom, $urandom};
    load(rk, 1'b1);
    wait_ready(lat);
    sk_e = sk;
    for (int i = 0; i < 3; i++) begin
      pt[i] = {$urandom, $urandom};
      ct[i] = feistel(pt[i], sk_e);
    end
    load(rk, 1'b0);
    wait_ready(lat);
    sk_d = sk;
    for (int i = 0; i < 3; i++)
      chk($sformatf("roundtrip_%0d", i), 768'(feistel(ct[i], sk_d)), 768'(pt[i]));

    // Asynchronous reset mid-generation
    load(K2, 1'b1);
    repeat (7) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_ready", {767'd0, keyready}, 768'd0);
    chk("midreset_busy", {767'd0, busy}, 768'd0);
    chk("midreset_sk", sk, 768'd0);
    rst_n = 1'b1;
    repeat (20) tick();
    chk("postreset_busy", {767'd0, busy}, 768'd0);
    chk("postreset_ready", {767'd0, keyready}, 768'd0);
    chk("postreset_sk", sk, 768'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
